// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state encoding, the NOP and reset-PC constants, and the
// RISC-V base opcode values that the decode stage also uses.
package if_fetch_pkg;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NopInstr       = 32'h0000_0013;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    // RISC-V base opcodes (instr[6:0])
    localparam logic [6:0] OpcLoad   = 7'b000_0011;
    localparam logic [6:0] OpcMiscMem = 7'b000_1111;
    localparam logic [6:0] OpcOpImm  = 7'b001_0011;
    localparam logic [6:0] OpcAuipc  = 7'b001_0111;
    localparam logic [6:0] OpcStore  = 7'b010_0011;
    localparam logic [6:0] OpcOp     = 7'b011_0011;
    localparam logic [6:0] OpcLui    = 7'b011_0111;
    localparam logic [6:0] OpcBranch = 7'b110_0011;
    localparam logic [6:0] OpcJalr   = 7'b110_0111;
    localparam logic [6:0] OpcJal    = 7'b110_1111;
    localparam logic [6:0] OpcSystem = 7'b111_0011;

endpackage

// File: rtl/if_pc_reg.sv
// Fetch program-counter register.
// Loads RESET_PC on reset, advances by 4 (modulo 2^32) on advance, and loads
// the word-aligned redirect target on redirect_valid (redirect wins).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   advance         step fetch_pc by 4
//   redirect_valid  load redirect_pc with bits [1:0] cleared
//   redirect_pc     redirect target
//   fetch_pc        current fetch address
module if_pc_reg
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h0000_0003;
        end else if (advance) begin
            pc_d = pc_q + 32'd4; // wraps naturally at 2^32
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fetch_pc = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage for the unpipelined RISC-V core.
// Issues one request at a time to instruction memory, holds the returned word
// for decode, and honours redirects from execute and stalls from decode.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req_valid/ready         request handshake, imem_addr word-aligned
//   imem_rsp_valid/data          response, one per accepted request
//   redirect_valid/redirect_pc   restart fetch at target (highest priority)
//   id_ready                     decode consumes the held instruction
//   instr_valid, instrCode,      held instruction and its address / address+4
//   PC, PC_4
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DefaultResetPc,
    parameter logic [31:0] NOP_INSTR = NopInstr
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        instr_valid,
    output logic [31:0] instrCode,
    output logic [31:0] PC,
    output logic [31:0] PC_4
);

    fetch_state_e state_q, state_d;
    logic         kill_q, kill_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         advance;
    logic [31:0]  fetch_pc;

    if_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc)
    );

    assign imem_req_valid = (state_q == StFetch);
    assign imem_addr      = {fetch_pc[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        advance = 1'b0;

        if (redirect_valid) begin
            // Any held or in-flight instruction belongs to the old path.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            unique case (state_q)
                StFetch: begin
                    if (imem_req_ready) begin
                        // Request leaves this cycle; its response must be dropped.
                        state_d = StWait;
                        kill_d  = 1'b1;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        state_d = StFetch;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                StHold: begin
                    state_d = StFetch;
                end
                default: begin
                    state_d = StFetch;
                    kill_d  = 1'b0;
                end
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = StFetch;
                        end else begin
                            valid_d = 1'b1;
                            instr_d = imem_rsp_data;
                            pc_d    = fetch_pc;
                            pc4_d   = fetch_pc + 32'd4;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (id_ready) begin
                        advance = 1'b1;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign instr_valid = valid_q;
    assign instrCode   = instr_q;
    assign PC          = pc_q;
    assign PC_4        = pc4_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle table of inputs and the outputs
// expected in that cycle, plus hand-written reset sequences.
module tb_if_fetch;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instrCode;
    logic [31:0] PC;
    logic [31:0] PC_4;

    int n_checks = 0;
    int n_fails  = 0;

    if_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .instr_valid    (instr_valid),
        .instrCode      (instrCode),
        .PC             (PC),
        .PC_4           (PC_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        idr;
        logic        reqv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ic;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    localparam int NVec = 31;
    vec_t vecs[NVec];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic redir,
                                logic [31:0] rpc, logic idr, logic reqv, logic [31:0] addr,
                                logic iv, logic [31:0] ic, logic [31:0] pc, logic [31:0] pc4);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.idr = idr;
        v.reqv = reqv; v.addr = addr; v.iv = iv; v.ic = ic; v.pc = pc; v.pc4 = pc4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic reqv, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ic, input logic [31:0] pc,
                              input logic [31:0] pc4);
        check({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, reqv});
        check({tag, " addr"}, imem_addr, addr);
        check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, iv});
        check({tag, " instrCode"}, instrCode, ic);
        check({tag, " PC"}, PC, pc);
        check({tag, " PC_4"}, PC_4, pc4);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b0;
    endtask

    initial begin
        //              rdy rv  rdata         rd  rpc           idr  reqv addr          iv ic            pc            pc4
        // Cold start, zero-wait memory
        vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0,        0, Nop,          32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 32'h00500093, 0, 32'h0,        0,   0, 32'h0,        0, Nop,          32'h0,        32'h0);
        // Decode stalls five cycles
        vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0,        1, 32'h00500093, 32'h0,        32'h4);
        // Next request at 4, memory not ready for one cycle
        vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h4,        0, Nop,          32'h0,        32'h4);
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h4,        0, Nop,          32'h0,        32'h4);
        // Redirect in WAIT: following response is dropped
        vecs[10] = mk(0, 0, 32'h0,        1, 32'h00000103, 0,   0, 32'h4,        0, Nop,          32'h0,        32'h4);
        vecs[11] = mk(0, 1, 32'hDEADBEEF, 0, 32'h0,        0,   0, 32'h100,      0, Nop,          32'h0,        32'h4);
        vecs[12] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h100,      0, Nop,          32'h0,        32'h4);
        vecs[13] = mk(0, 1, 32'h00A00113, 0, 32'h0,        0,   0, 32'h100,      0, Nop,          32'h0,        32'h4);
        vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h100,      1, 32'h00A00113, 32'h100,      32'h104);
        // Redirect coinciding with the response
        vecs[15] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h104,      0, Nop,          32'h100,      32'h104);
        vecs[16] = mk(0, 1, 32'h11111111, 1, 32'h00000200, 0,   0, 32'h104,      0, Nop,          32'h100,      32'h104);
        // Stray response in FETCH is ignored
        vecs[17] = mk(0, 1, 32'h33333333, 0, 32'h0,        0,   1, 32'h200,      0, Nop,          32'h100,      32'h104);
        // Redirect in the same cycle the request is accepted
        vecs[18] = mk(1, 0, 32'h0,        1, 32'hFFFFFFFE, 0,   1, 32'h200,      0, Nop,          32'h100,      32'h104);
        vecs[19] = mk(0, 1, 32'h22222222, 0, 32'h0,        0,   0, 32'hFFFFFFFC, 0, Nop,          32'h100,      32'h104);
        // Wrap-around at the top of the address space
        vecs[20] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, Nop,          32'h100,      32'h104);
        vecs[21] = mk(0, 1, 32'h00000073, 0, 32'h0,        0,   0, 32'hFFFFFFFC, 0, Nop,          32'h100,      32'h104);
        vecs[22] = mk(0, 0, 32'h0,        0, 32'h0,        1,   0, 32'hFFFFFFFC, 1, 32'h00000073, 32'hFFFFFFFC, 32'h0);
        vecs[23] = mk(0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0,        0, Nop,          32'hFFFFFFFC, 32'h0);
        vecs[24] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0,        0, Nop,          32'hFFFFFFFC, 32'h0);
        vecs[25] = mk(0, 1, 32'h00100093, 0, 32'h0,        0,   0, 32'h0,        0, Nop,          32'hFFFFFFFC, 32'h0);
        // Redirect in HOLD overrides id_ready
        vecs[26] = mk(0, 0, 32'h0,        1, 32'h00000040, 1,   0, 32'h0,        1, 32'h00100093, 32'h0,        32'h4);
        vecs[27] = mk(0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h40,       0, Nop,          32'h0,        32'h4);
        vecs[28] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h40,       0, Nop,          32'h0,        32'h4);
        vecs[29] = mk(0, 1, 32'h00300193, 0, 32'h0,        0,   0, 32'h40,       0, Nop,          32'h0,        32'h4);
        vecs[30] = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h40,       1, 32'h00300193, 32'h40,       32'h44);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 1'b1, 32'h0, 1'b0, Nop, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVec; i++) begin
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rv;
            imem_rsp_data  = vecs[i].rdata;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].idr;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].reqv, vecs[i].addr, vecs[i].iv,
                       vecs[i].ic, vecs[i].pc, vecs[i].pc4);
            @(negedge clk);
        end

        // Still holding 00300193 at 0x40; reset must clear it without a clock edge.
        idle_inputs();
        #1;
        check("pre-reset hold valid", {31'd0, instr_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_outs("async reset", 1'b1, 32'h0, 1'b0, Nop, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check_outs("post-reset req", 1'b1, 32'h0, 1'b0, Nop, 32'h0, 32'h0);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00700213;
        #1;
        check("post-reset wait req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_outs("post-reset capture", 1'b0, 32'h0, 1'b1, 32'h00700213, 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
